// File: rtl/utf8_pkg.sv
// Shared types and constants for the UTF-8 decoder.
package utf8_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CP_W   = 21;

    localparam logic [CP_W-1:0] BOM_CP              = 21'h00FEFF;
    localparam logic [CP_W-1:0] REPLACEMENT_DEFAULT = 21'h00FFFD;

    localparam logic [BYTE_W-1:0] CONT_MIN = 8'h80;
    localparam logic [BYTE_W-1:0] CONT_MAX = 8'hBF;

    // NEEDn: n continuation bytes still outstanding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NEED1 = 2'd1,
        NEED2 = 2'd2,
        NEED3 = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ASCII   = 3'd0,
        LEAD2   = 3'd1,
        LEAD3   = 3'd2,
        LEAD4   = 3'd3,
        INVALID = 3'd4
    } lead_class_e;

    // Output slot payload
    typedef struct packed {
        logic [CP_W-1:0] cp;
        logic            err;
    } cp_out_t;

endpackage

// File: rtl/utf8_lead_classify.sv
// Lead-byte classifier: class of a byte and the legal range of the first
// continuation byte that may follow it (rules out overlongs, surrogates
// and codepoints above U+10FFFF).
module utf8_lead_classify
    import utf8_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output lead_class_e       lead_class_c,
    output logic [BYTE_W-1:0] cont_min_c,
    output logic [BYTE_W-1:0] cont_max_c
);

    // Class and first-continuation bounds
    always_comb begin
        lead_class_c = INVALID;
        cont_min_c   = CONT_MIN;
        cont_max_c   = CONT_MAX;
        if (in_byte <= 8'h7F) begin
            lead_class_c = ASCII;
        end else if (in_byte >= 8'hC2 && in_byte <= 8'hDF) begin
            lead_class_c = LEAD2;
        end else if (in_byte >= 8'hE0 && in_byte <= 8'hEF) begin
            lead_class_c = LEAD3;
            if (in_byte == 8'hE0) begin
                cont_min_c = 8'hA0;
            end else if (in_byte == 8'hED) begin
                cont_max_c = 8'h9F;
            end
        end else if (in_byte >= 8'hF0 && in_byte <= 8'hF4) begin
            lead_class_c = LEAD4;
            if (in_byte == 8'hF0) begin
                cont_min_c = 8'h90;
            end else if (in_byte == 8'hF4) begin
                cont_max_c = 8'h8F;
            end
        end
    end

endmodule

// File: rtl/utf8_decoder.sv
// Streaming UTF-8 to codepoint decoder with a single registered output slot.
// Optional: define UTF8_BOM_STRIP_EN to drop a leading U+FEFF after reset.
module utf8_decoder
    import utf8_pkg::*;
#(
    parameter logic [CP_W-1:0] REPLACEMENT_CP = REPLACEMENT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CP_W-1:0]   out_cp,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e              state_q, state_d;
    logic [CP_W-1:0]     acc_q, acc_d;
    logic [BYTE_W-1:0]   cmin_q, cmin_d;
    logic [BYTE_W-1:0]   cmax_q, cmax_d;
    cp_out_t             slot_q, slot_d;
    logic                out_valid_q, out_valid_d;
`ifdef UTF8_BOM_STRIP_EN
    logic                first_q, first_d;
`endif

    lead_class_e         lead_class;
    logic [BYTE_W-1:0]   lead_min;
    logic [BYTE_W-1:0]   lead_max;
    logic                slot_free;
    logic                cont_ok;
    logic                ready_int;
    logic                load;
    cp_out_t             load_val;
    logic [CP_W-1:0]     acc_next;

    utf8_lead_classify u_classify (
        .in_byte      (in_byte),
        .lead_class_c (lead_class),
        .cont_min_c   (lead_min),
        .cont_max_c   (lead_max)
    );

    // Handshake qualifiers
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        cont_ok   = (in_byte >= cmin_q) && (in_byte <= cmax_q);
        ready_int = slot_free && ((state_q == IDLE) || cont_ok);
        acc_next  = CP_W'({acc_q, in_byte[5:0]});
    end

    assign in_ready  = reset_n && ready_int;
    assign out_cp    = slot_q.cp;
    assign out_err   = slot_q.err;
    assign out_valid = out_valid_q;

    // Next-state decode, accumulation and output slot loading
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cmin_d      = cmin_q;
        cmax_d      = cmax_q;
        slot_d      = slot_q;
        out_valid_d = out_valid_q && !out_ready;
`ifdef UTF8_BOM_STRIP_EN
        first_d     = first_q;
`endif
        load        = 1'b0;
        load_val    = '{cp: REPLACEMENT_CP, err: 1'b1};

        if (in_valid && slot_free) begin
            if (state_q == IDLE) begin
                cmin_d = lead_min;
                cmax_d = lead_max;
                unique case (lead_class)
                    ASCII: begin
                        load     = 1'b1;
                        load_val = '{cp: CP_W'(in_byte[6:0]), err: 1'b0};
                    end
                    LEAD2: begin
                        acc_d   = CP_W'(in_byte[4:0]);
                        state_d = NEED1;
                    end
                    LEAD3: begin
                        acc_d   = CP_W'(in_byte[3:0]);
                        state_d = NEED2;
                    end
                    LEAD4: begin
                        acc_d   = CP_W'(in_byte[2:0]);
                        state_d = NEED3;
                    end
                    default: begin
                        load = 1'b1;
                    end
                endcase
            end else if (cont_ok) begin
                acc_d  = acc_next;
                cmin_d = CONT_MIN;
                cmax_d = CONT_MAX;
                unique case (state_q)
                    NEED3:   state_d = NEED2;
                    NEED2:   state_d = NEED1;
                    default: begin
                        state_d  = IDLE;
                        load     = 1'b1;
                        load_val = '{cp: acc_next, err: 1'b0};
                    end
                endcase
            end else begin
                // Offending byte stays on the input and is re-decoded as a lead
                state_d = IDLE;
                load    = 1'b1;
            end
        end

        if (load) begin
`ifdef UTF8_BOM_STRIP_EN
            first_d = 1'b0;
            if (!(first_q && !load_val.err && load_val.cp == BOM_CP)) begin
                slot_d      = load_val;
                out_valid_d = 1'b1;
            end
`else
            slot_d      = load_val;
            out_valid_d = 1'b1;
`endif
        end
    end

    // State and slot registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cmin_q      <= CONT_MIN;
            cmax_q      <= CONT_MAX;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef UTF8_BOM_STRIP_EN
            first_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cmin_q      <= cmin_d;
            cmax_q      <= cmax_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
`ifdef UTF8_BOM_STRIP_EN
            first_q     <= first_d;
`endif
        end
    end

endmodule

// File: tb/tb_utf8_decoder.sv
// Directed-vector bench for utf8_decoder.
module tb_utf8_decoder;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] out_cp;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    int n_vec;
    int n_err;
    int cyc;

    logic        accepted;
    logic        obs_valid;
    logic [20:0] obs_cp;
    logic        obs_err;
    logic        obs_in_ready;

    logic [7:0]  tx_q[$];
    logic [20:0] cap_cp[$];
    logic        cap_err[$];
    int          cap_cyc[$];

    utf8_decoder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_cp    (out_cp),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: inputs were set at the negedge; observe, then advance.
    task automatic cycle();
        #1;
        accepted     = in_valid && in_ready;
        obs_valid    = out_valid;
        obs_cp       = out_cp;
        obs_err      = out_err;
        obs_in_ready = in_ready;
        if (out_valid && out_ready) begin
            cap_cp.push_back(out_cp);
            cap_err.push_back(out_err);
            cap_cyc.push_back(cyc);
        end
        @(negedge clock);
        cyc++;
    endtask

    // Push tx_q into the DUT one byte per accepted handshake, bounded.
    task automatic feed(output int ncyc);
        ncyc = 0;
        while (tx_q.size() > 0 && ncyc < 64) begin
            in_valid = 1'b1;
            in_byte  = tx_q[0];
            cycle();
            ncyc++;
            if (accepted) void'(tx_q.pop_front());
        end
        in_valid = 1'b0;
        n_vec++;
        if (tx_q.size() != 0) begin
            n_err++;
            $display("FAIL feed_timeout: %0d bytes left, required 0", tx_q.size());
            tx_q.delete();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_cap();
        cap_cp.delete();
        cap_err.delete();
        cap_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'h41;
        out_ready = 1'b1;
        cycle();
        cycle();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        clear_cap();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'h41;
        out_ready = 1'b1;
        cycle();
        cycle();
        n_vec++;
        if (obs_in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready: got %b, required 0", obs_in_ready);
        end
        n_vec++;
        if (obs_valid !== 1'b0 || obs_cp !== 21'h0 || obs_err !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b cp=%h e=%b, required v=0 cp=0 e=0",
                              obs_valid, obs_cp, obs_err);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        cycle();
        n_vec++;
        if (obs_in_ready !== 1'b1) begin
            n_err++; $display("FAIL idle_in_ready: got %b, required 1", obs_in_ready);
        end
        clear_cap();
    endtask

    task automatic test_ascii();
        int acc_cyc;
        clear_cap();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_byte   = 8'h41;
        cycle();
        acc_cyc = cyc - 1;
        n_vec++;
        if (accepted !== 1'b1) begin
            n_err++; $display("FAIL ascii_accept: got %b, required 1", accepted);
        end
        in_valid = 1'b0;
        cycle();
        n_vec++;
        if (obs_valid !== 1'b1 || obs_cp !== 21'h41 || obs_err !== 1'b0) begin
            n_err++; $display("FAIL ascii_out: got v=%b cp=%h e=%b, required v=1 cp=000041 e=0",
                              obs_valid, obs_cp, obs_err);
        end
        n_vec++;
        if (cap_cyc.size() != 1 || cap_cyc[0] != acc_cyc + 1) begin
            n_err++; $display("FAIL ascii_latency: got %0d outputs, required 1 at cycle %0d",
                              cap_cyc.size(), acc_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_cp[$];
        int ncyc;
        clear_cap();
        out_ready = 1'b1;
        tx_q   = '{8'hE2, 8'h82, 8'hAC, 8'hF0, 8'h9F, 8'h98, 8'h80,
                   8'hF4, 8'h8F, 8'hBF, 8'hBF, 8'hC2, 8'h80};
        exp_cp = '{21'h020AC, 21'h1F600, 21'h10FFFF, 21'h00080};
        feed(ncyc);
        drain(2);
        n_vec++;
        if (ncyc != 13) begin
            n_err++; $display("FAIL b2b_bubbles: got %0d cycles, required 13", ncyc);
        end
        n_vec++;
        if (cap_cp.size() != exp_cp.size()) begin
            n_err++; $display("FAIL b2b_count: got %0d, required %0d", cap_cp.size(), exp_cp.size());
        end
        for (int i = 0; i < exp_cp.size() && i < cap_cp.size(); i++) begin
            n_vec++;
            if (cap_cp[i] !== exp_cp[i] || cap_err[i] !== 1'b0) begin
                n_err++; $display("FAIL b2b_cp[%0d]: got cp=%h e=%b, required cp=%h e=0",
                                  i, cap_cp[i], cap_err[i], exp_cp[i]);
            end
        end
    endtask

    task automatic test_malformed();
        logic [20:0] exp_cp[$];
        logic        exp_err[$];
        int ncyc;
        clear_cap();
        out_ready = 1'b1;
        tx_q    = '{8'hC3, 8'h41, 8'hC0, 8'hED, 8'hA0, 8'h80, 8'hF4, 8'h90};
        exp_cp  = '{21'hFFFD, 21'h41, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'hFFFD, 21'hFFFD};
        exp_err = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        feed(ncyc);
        drain(2);
        n_vec++;
        if (cap_cp.size() != exp_cp.size()) begin
            n_err++; $display("FAIL bad_count: got %0d, required %0d", cap_cp.size(), exp_cp.size());
        end
        for (int i = 0; i < exp_cp.size() && i < cap_cp.size(); i++) begin
            n_vec++;
            if (cap_cp[i] !== exp_cp[i] || cap_err[i] !== exp_err[i]) begin
                n_err++; $display("FAIL bad_cp[%0d]: got cp=%h e=%b, required cp=%h e=%b",
                                  i, cap_cp[i], cap_err[i], exp_cp[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_cap();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_byte   = 8'hE2; cycle();
        in_byte   = 8'h82; cycle();
        in_byte   = 8'hAC; cycle();
        out_ready = 1'b0;
        in_byte   = 8'h41;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if (obs_valid !== 1'b1 || obs_cp !== 21'h20AC || obs_in_ready !== 1'b0 || accepted !== 1'b0) begin
                n_err++; $display("FAIL stall[%0d]: got v=%b cp=%h rdy=%b, required v=1 cp=0020ac rdy=0",
                                  i, obs_valid, obs_cp, obs_in_ready);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_vec++;
        if (accepted !== 1'b1) begin
            n_err++; $display("FAIL stall_release_accept: got %b, required 1", accepted);
        end
        in_valid = 1'b0;
        drain(2);
        n_vec++;
        if (cap_cp.size() != 2 || cap_cp[0] !== 21'h20AC || cap_cp[1] !== 21'h41) begin
            n_err++; $display("FAIL stall_outputs: got %0d outputs, required 0020ac then 000041",
                              cap_cp.size());
        end
    endtask

    task automatic test_reset_mid();
        int ncyc;
        clear_cap();
        out_ready = 1'b1;
        tx_q = '{8'hE2, 8'h82};
        feed(ncyc);
        drain(1);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hAC;
        cycle();
        n_vec++;
        if (obs_in_ready !== 1'b0 || accepted !== 1'b0) begin
            n_err++; $display("FAIL midrst_in_ready: got %b, required 0", obs_in_ready);
        end
        cycle();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        n_vec++;
        if (obs_valid !== 1'b0 || cap_cp.size() != 0) begin
            n_err++; $display("FAIL midrst_quiet: got v=%b n=%0d, required v=0 n=0", obs_valid, cap_cp.size());
        end
        tx_q = '{8'hAC, 8'h41};
        feed(ncyc);
        drain(2);
        n_vec++;
        if (cap_cp.size() != 2 || cap_cp[0] !== 21'hFFFD || cap_err[0] !== 1'b1
            || cap_cp[1] !== 21'h41 || cap_err[1] !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: got %0d outputs, required fffd(err) then 000041",
                              cap_cp.size());
        end
    endtask

    task automatic test_bom();
        logic [20:0] exp_cp[$];
        int ncyc;
        do_reset();
        tx_q = '{8'hEF, 8'hBB, 8'hBF, 8'h48, 8'hEF, 8'hBB, 8'hBF};
`ifdef UTF8_BOM_STRIP_EN
        exp_cp = '{21'h48, 21'hFEFF};
`else
        exp_cp = '{21'hFEFF, 21'h48, 21'hFEFF};
`endif
        feed(ncyc);
        drain(2);
        n_vec++;
        if (cap_cp.size() != exp_cp.size()) begin
            n_err++; $display("FAIL bom_count: got %0d, required %0d", cap_cp.size(), exp_cp.size());
        end
        for (int i = 0; i < exp_cp.size() && i < cap_cp.size(); i++) begin
            n_vec++;
            if (cap_cp[i] !== exp_cp[i] || cap_err[i] !== 1'b0) begin
                n_err++; $display("FAIL bom_cp[%0d]: got cp=%h e=%b, required cp=%h e=0",
                                  i, cap_cp[i], cap_err[i], exp_cp[i]);
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_ascii();
        test_back_to_back();
        test_malformed();
        test_backpressure();
        test_reset_mid();
        test_bom();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/utf8_decoder.md
UTF8_DECODER -- requirements
Module: utf8_decoder

Interface
REQ-001 SHALL have parameter: REPLACEMENT_CP, 21'h00FFFD, codepoint emitted for any malformed sequence.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 SHALL have port: in_byte  input  8  UTF-8 byte stream.
REQ-005 SHALL have port: in_valid  input  1  in_byte valid.
REQ-006 SHALL have port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-007 SHALL have port: out_cp  output  21  decoded codepoint.
REQ-008 SHALL have port: out_err  output  1  out_cp is REPLACEMENT_CP due to malformed input.
REQ-009 SHALL have port: out_valid  output  1  out_cp/out_err valid.
REQ-010 SHALL have port: out_ready  input  1  codepoint consumed when out_valid && out_ready.

Function
REQ-011 SHALL hold a single-entry registered output slot; slot_free = !out_valid || out_ready.
REQ-012 SHALL implement states IDLE, NEED1, NEED2, NEED3; NEEDn means n continuation bytes outstanding.
REQ-013 SHALL classify lead bytes:
- 00-7F: ASCII
- C2-DF: 2-byte, next NEED1
- E0-EF: 3-byte, next NEED2
- F0-F4: 4-byte, next NEED3
- 80-C1, F5-FF: invalid
REQ-014 SHALL, in IDLE with slot_free: assert in_ready; ASCII loads out_cp={13'b0,byte} with out_valid=1 next cycle (latency 1); invalid lead byte is consumed and emits REPLACEMENT_CP with out_err=1.
REQ-015 SHALL accumulate payload bits into a 21-bit register: lead contributes 7/5/4/3 bits, each continuation 6 bits (shift left 6, OR byte[5:0]).
REQ-016 SHALL restrict the first continuation byte by lead: E0 -> A0-BF, ED -> 80-9F, F0 -> 90-BF, F4 -> 80-8F, otherwise 80-BF; later continuations 80-BF.
REQ-017 SHALL, in NEEDn with slot_free and an allowed continuation byte: assert in_ready, consume the byte, decrement n; on final byte load the codepoint into the slot (out_valid next cycle) and return to IDLE.
REQ-018 SHALL, in NEEDn with in_valid and a disallowed byte: deassert in_ready (byte not consumed), emit REPLACEMENT_CP with out_err=1 when slot_free, and go to IDLE, so the byte is re-decoded as a lead next cycle.
REQ-019 SHALL deassert in_ready whenever !slot_free; out_cp/out_err SHALL be stable while out_valid && !out_ready.
REQ-020 SHALL sustain one byte per cycle with out_ready held high.

Reset
REQ-021 SHALL, while reset_n=0: state=IDLE, accumulator=0, out_valid=0, out_cp=0, out_err=0, BOM-first flag=1; any partial sequence is discarded without error output.
REQ-022 SHALL hold in_ready=0 during any cycle in which reset_n=0.

Configuration
REQ-023 SHALL, with UTF8_BOM_STRIP_EN defined, silently drop the first decoded codepoint after reset if it equals 21'h00FEFF, with no out_valid pulse; the first-codepoint flag clears on the first decoded codepoint or error, whether or not it was dropped.
REQ-024 SHALL, without UTF8_BOM_STRIP_EN, output U+FEFF like any other codepoint and omit the flag register.

Structure
REQ-025 SHALL place in shared package utf8_pkg: the state enum (IDLE, NEED1-3), the lead-class enum (ASCII, LEAD2, LEAD3, LEAD4, INVALID), and constants BOM_CP=21'h00FEFF and REPLACEMENT_DEFAULT=21'h00FFFD.
REQ-026 SHALL use one combinational sub-module, utf8_lead_classify, mapping a byte to its lead class and to the first-continuation min/max bounds.

Verification
REQ-027 SHALL test: 41 with out_ready=1 -> cycle +1 out_cp=0x41, out_err=0.
REQ-028 SHALL test: E2 82 AC -> 0x20AC; F0 9F 98 80 -> 0x1F600; back-to-back, no bubbles.
REQ-029 SHALL test: C3 41 -> FFFD with out_err=1, then 0x41; C0 -> FFFD with err; ED A0 80 -> FFFD, FFFD, FFFD.
REQ-030 SHALL test: out_ready=0 for 5 cycles with E2 82 AC pending -> in_ready=0, out_cp=0x20AC held stable, no byte loss.
REQ-031 SHALL test: reset_n=0 after E2 82, then AC 41 -> FFFD with err for AC, then 0x41.
REQ-032 SHALL test with UTF8_BOM_STRIP_EN defined: EF BB BF 48 -> only 0x48; a second EF BB BF -> 0xFEFF output.
